// File: rtl/npc_pkg.sv
// Shared NPC core constants and types used by the GPR file and its commit tracker.
package npc_pkg;

    localparam int XLEN       = 64;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int A0_IDX     = 10;

    // Run/halt controller states; RUN is the reset state.
    typedef enum logic {
        RF_RUN  = 1'b0,
        RF_HALT = 1'b1
    } rf_state_e;

endpackage

// File: rtl/gpr_commit_tracker.sv
// Run/halt controller, retire counter, commit-event register and halt-code capture
// for the architectural register file.
module gpr_commit_tracker
    import npc_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_valid,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic [XLEN-1:0]       wb_pc,
    input  logic                  wb_ebreak,
    input  logic [XLEN-1:0]       a0_cur,
    output logic                  run,
    output logic                  commit_valid,
    output logic [XLEN-1:0]       commit_pc,
    output logic [REG_ADDR_W-1:0] commit_rd,
    output logic [XLEN-1:0]       commit_data,
    output logic [XLEN-1:0]       retire_cnt,
    output logic                  halted,
    output logic [XLEN-1:0]       halt_code
);

    rf_state_e       state;
    logic            write_ok;
    logic [XLEN-1:0] a0_next;

    // A write takes effect only with the enable set and a non-zero destination.
    assign write_ok = wb_we && (wb_rd != '0);

    // a0 as it will read after this edge, so an ebreak that writes x10 reports the new value.
    assign a0_next = (write_ok && (wb_rd == REG_ADDR_W'(A0_IDX))) ? wb_data : a0_cur;

    assign run = (state == RF_RUN);

    // Controller: retire bookkeeping in RUN, everything frozen in HALT until reset.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RF_RUN;
            commit_valid <= 1'b0;
            commit_pc    <= '0;
            commit_rd    <= '0;
            commit_data  <= '0;
            retire_cnt   <= '0;
            halted       <= 1'b0;
            halt_code    <= '0;
        end else begin
            commit_valid <= 1'b0;
            case (state)
                RF_RUN: begin
                    if (wb_valid) begin
                        commit_valid <= 1'b1;
                        commit_pc    <= wb_pc;
                        commit_rd    <= write_ok ? wb_rd : '0;
                        commit_data  <= write_ok ? wb_data : '0;
                        retire_cnt   <= retire_cnt + 1'b1;
                        if (wb_ebreak) begin
                            state     <= RF_HALT;
                            halted    <= 1'b1;
                            halt_code <= a0_next;
                        end
                    end
                end
                RF_HALT: begin
                    state <= RF_HALT;
                end
                default: begin
                    state <= RF_RUN;
                end
            endcase
        end
    end

endmodule

// File: rtl/gpr_regfile.sv
// RV64 architectural register file: 32 x 64-bit GPRs, two bypassed combinational read
// ports, one write-back port, x0 hard-wired to zero, and every register exported flat
// to the trace stage alongside the commit/halt events.
module gpr_regfile
    import npc_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    input  logic                  wb_valid,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic [XLEN-1:0]       wb_pc,
    input  logic                  wb_ebreak,
    output logic                  commit_valid,
    output logic [XLEN-1:0]       commit_pc,
    output logic [REG_ADDR_W-1:0] commit_rd,
    output logic [XLEN-1:0]       commit_data,
    output logic [XLEN-1:0]       retire_cnt,
    output logic                  halted,
    output logic [XLEN-1:0]       halt_code,
    output logic [XLEN-1:0]       gpr_0,
    output logic [XLEN-1:0]       gpr_1,
    output logic [XLEN-1:0]       gpr_2,
    output logic [XLEN-1:0]       gpr_3,
    output logic [XLEN-1:0]       gpr_4,
    output logic [XLEN-1:0]       gpr_5,
    output logic [XLEN-1:0]       gpr_6,
    output logic [XLEN-1:0]       gpr_7,
    output logic [XLEN-1:0]       gpr_8,
    output logic [XLEN-1:0]       gpr_9,
    output logic [XLEN-1:0]       gpr_10,
    output logic [XLEN-1:0]       gpr_11,
    output logic [XLEN-1:0]       gpr_12,
    output logic [XLEN-1:0]       gpr_13,
    output logic [XLEN-1:0]       gpr_14,
    output logic [XLEN-1:0]       gpr_15,
    output logic [XLEN-1:0]       gpr_16,
    output logic [XLEN-1:0]       gpr_17,
    output logic [XLEN-1:0]       gpr_18,
    output logic [XLEN-1:0]       gpr_19,
    output logic [XLEN-1:0]       gpr_20,
    output logic [XLEN-1:0]       gpr_21,
    output logic [XLEN-1:0]       gpr_22,
    output logic [XLEN-1:0]       gpr_23,
    output logic [XLEN-1:0]       gpr_24,
    output logic [XLEN-1:0]       gpr_25,
    output logic [XLEN-1:0]       gpr_26,
    output logic [XLEN-1:0]       gpr_27,
    output logic [XLEN-1:0]       gpr_28,
    output logic [XLEN-1:0]       gpr_29,
    output logic [XLEN-1:0]       gpr_30,
    output logic [XLEN-1:0]       gpr_31
);

    // x0 has no storage; index 0 is never written or read from the array.
    logic [XLEN-1:0] regs [1:NREG-1];
    logic            run;
    logic            wr_qual;

    // A write is qualified only while running, on a retiring beat, to a non-zero rd.
    assign wr_qual = run && wb_valid && wb_we && (wb_rd != '0);

    // Register array update.
    // NOTE: the array is reset because the trace port must show zeros after reset; this keeps it in flops, not RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_qual) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Read port 1: x0 reads zero, same-cycle write is forwarded, else the array.
    // NOTE: combinational outputs get a default first so no path can infer a latch.
    always_comb begin
        rs1_data = '0;
        if (rs1_addr != '0) begin
            rs1_data = (wr_qual && (wb_rd == rs1_addr)) ? wb_data : regs[rs1_addr];
        end
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        rs2_data = '0;
        if (rs2_addr != '0) begin
            rs2_data = (wr_qual && (wb_rd == rs2_addr)) ? wb_data : regs[rs2_addr];
        end
    end

    gpr_commit_tracker #(
        .XLEN (XLEN)
    ) u_tracker (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_valid     (wb_valid),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_pc        (wb_pc),
        .wb_ebreak    (wb_ebreak),
        .a0_cur       (regs[A0_IDX]),
        .run          (run),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_rd    (commit_rd),
        .commit_data  (commit_data),
        .retire_cnt   (retire_cnt),
        .halted       (halted),
        .halt_code    (halt_code)
    );

    assign gpr_0  = '0;
    assign gpr_1  = regs[1];
    assign gpr_2  = regs[2];
    assign gpr_3  = regs[3];
    assign gpr_4  = regs[4];
    assign gpr_5  = regs[5];
    assign gpr_6  = regs[6];
    assign gpr_7  = regs[7];
    assign gpr_8  = regs[8];
    assign gpr_9  = regs[9];
    assign gpr_10 = regs[10];
    assign gpr_11 = regs[11];
    assign gpr_12 = regs[12];
    assign gpr_13 = regs[13];
    assign gpr_14 = regs[14];
    assign gpr_15 = regs[15];
    assign gpr_16 = regs[16];
    assign gpr_17 = regs[17];
    assign gpr_18 = regs[18];
    assign gpr_19 = regs[19];
    assign gpr_20 = regs[20];
    assign gpr_21 = regs[21];
    assign gpr_22 = regs[22];
    assign gpr_23 = regs[23];
    assign gpr_24 = regs[24];
    assign gpr_25 = regs[25];
    assign gpr_26 = regs[26];
    assign gpr_27 = regs[27];
    assign gpr_28 = regs[28];
    assign gpr_29 = regs[29];
    assign gpr_30 = regs[30];
    assign gpr_31 = regs[31];

endmodule
